// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: two-flop synchroniser plus shared-tick debouncer for slide switches,
// producing clean levels and one-cycle rise/fall strobes per bit.
module sw_debounce_sync #(
    parameter int WIDTH        = 18,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             tick
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sw_sync;
    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [CW-1:0]    cnt [WIDTH];

    assign pre_nxt = (pre == PMAX) ? '0 : pre + PW'(1);

    // tick is registered so it is low during reset even when TICK_DIV=1
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sw_sync <= '0;
            pre     <= '0;
            tick    <= 1'b0;
        end else begin
            sync1   <= sw_raw;
            sw_sync <= sync1;
            pre     <= pre_nxt;
            tick    <= (pre_nxt == PMAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_out  <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sw_sync[i] == sw_out[i])
                    cnt[i] <= '0;
                else if (tick && cnt[i] == CMAX) begin
                    sw_out[i]  <= sw_sync[i];
                    sw_rise[i] <= sw_sync[i];
                    sw_fall[i] <= ~sw_sync[i];
                    cnt[i]     <= '0;
                end else if (tick)
                    cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb_sw_debounce_sync: randomized and directed checks of sw_debounce_sync against a
// behavioural model, plus a degenerate-parameter instance checked as a pure 3-clk delay.
module tb_sw_debounce_sync;
    localparam int W  = 18;
    localparam int TD = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out, sw_rise, sw_fall, out2, rise2, fall2;
    logic tick, tick2;

    always #5 clk = ~clk;

    sw_debounce_sync #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw),
        .sw_out(sw_out), .sw_rise(sw_rise), .sw_fall(sw_fall), .tick(tick));

    sw_debounce_sync #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1)) dut2 (
        .clk(clk), .reset(reset), .sw_raw(sw_raw),
        .sw_out(out2), .sw_rise(rise2), .sw_fall(fall2), .tick(tick2));

    int checks = 0;
    int errors = 0;
    logic go = 1'b0;
    logic [W-1:0] raw = '1;
    logic rst = 1'b1;

    // model state: raw history, accepted level, ticks seen during current disagreement
    logic [W-1:0] h1 = '0, h2 = '0, m_out = '0, m_rise = '0, m_fall = '0;
    logic m_tick = 1'b0;
    int m_seen [W];
    int t = 0;
    logic [W-1:0] g1 = '0, g2 = '0, e_out2 = '0, e_rise2 = '0, e_fall2 = '0;
    logic e_tick2 = 1'b0;

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_rng(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            h1 = '0; h2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0; t = 0;
            for (int i = 0; i < W; i++) m_seen[i] = 0;
            g1 = '0; g2 = '0; e_out2 = '0; e_rise2 = '0; e_fall2 = '0; e_tick2 = 1'b0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (h2[i] == m_out[i]) m_seen[i] = 0;
                else if (m_tick) begin
                    m_seen[i] = m_seen[i] + 1;
                    if (m_seen[i] == ST) begin
                        m_out[i] = h2[i];
                        m_rise[i] = h2[i];
                        m_fall[i] = ~h2[i];
                        m_seen[i] = 0;
                    end
                end
            end
            h2 = h1;
            h1 = raw;
            t++;
            m_tick = (t % TD == TD - 1);
            e_rise2 = g2 & ~e_out2;
            e_fall2 = ~g2 & e_out2;
            e_out2 = g2;
            g2 = g1;
            g1 = raw;
            e_tick2 = 1'b1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sw_raw = raw;
        reset = rst;
        @(posedge clk);
        #1;
        model_step();
        go = 1'b1;
    endtask

    task automatic measure(int b, logic v, output int lat, output int nr, output int nf);
        lat = 0; nr = 0; nf = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (lat == 0 && sw_out[b] == v) lat = k;
            nr += int'(sw_rise[b]);
            nf += int'(sw_fall[b]);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("sw_out", sw_out, m_out);
            chk("sw_rise", sw_rise, m_rise);
            chk("sw_fall", sw_fall, m_fall);
            chk("tick", W'(tick), W'(m_tick));
            chk("out2", out2, e_out2);
            chk("rise2", rise2, e_rise2);
            chk("fall2", fall2, e_fall2);
            chk("tick2", W'(tick2), W'(e_tick2));
        end
    end

    initial begin
        int lat, nr, nf, ns;
        repeat (3) cyc();
        chk("reset_out", sw_out, '0);
        chk("reset_tick", W'(tick), '0);
        rst = 1'b0;
        measure(0, 1'b1, lat, nr, nf);
        chk_rng("reset_lat", lat, 11, 14);
        chk_rng("reset_rise_cnt", nr, 1, 1);
        chk("reset_all_high", sw_out, 18'h3FFFF);

        raw = '0;
        repeat (20) cyc();
        chk("released_all", sw_out, 18'h0);
        raw[5] = 1'b1;
        measure(5, 1'b1, lat, nr, nf);
        chk_rng("step_lat", lat, 11, 14);
        chk_rng("step_rise_cnt", nr, 1, 1);
        chk_rng("step_fall_cnt", nf, 0, 0);
        chk("step_only_bit5", sw_out, 18'h00020);
        raw[5] = 1'b0;
        measure(5, 1'b0, lat, nr, nf);
        chk_rng("release_lat", lat, 11, 14);
        chk_rng("release_fall_cnt", nf, 1, 1);
        chk_rng("release_rise_cnt", nr, 0, 0);
        chk("release_all_low", sw_out, 18'h0);

        ns = 0;
        for (int k = 0; k < 39; k++) begin
            raw[0] = ((k / 3) % 2) == 1;
            cyc();
            ns += int'(sw_rise[0]) + int'(sw_fall[0]);
        end
        chk_rng("bounce_strobes", ns, 0, 0);
        raw[0] = 1'b1;
        measure(0, 1'b1, lat, nr, nf);
        chk_rng("bounce_lat", lat, 11, 14);
        chk_rng("bounce_rise_cnt", nr, 1, 1);
        raw[0] = 1'b0;
        repeat (20) cyc();

        ns = 0;
        raw[17] = 1'b1;
        repeat (4) begin cyc(); ns += int'(sw_rise[17]) + int'(sw_fall[17]); end
        raw[17] = 1'b0;
        repeat (20) begin cyc(); ns += int'(sw_rise[17]) + int'(sw_fall[17]); end
        chk_rng("glitch_strobes", ns, 0, 0);
        chk("glitch_out", W'(sw_out[17]), '0);
        nr = 0;
        raw[17] = 1'b1;
        repeat (12) begin cyc(); nr += int'(sw_rise[17]); end
        raw[17] = 1'b0;
        repeat (20) begin cyc(); nr += int'(sw_rise[17]); end
        chk_rng("pulse3_rise_cnt", nr, 1, 1);
        repeat (20) cyc();

        raw[9] = 1'b1;
        repeat (10) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        chk("midrst_out", sw_out, '0);
        rst = 1'b0;
        measure(9, 1'b1, lat, nr, nf);
        chk_rng("midrst_lat", lat, 11, 14);
        chk_rng("midrst_rise_cnt", nr, 1, 1);
        raw = '0;
        repeat (20) cyc();

        raw[3] = 1'b1;
        cyc();
        cyc();
        chk("degen_before", W'(out2[3]), '0);
        cyc();
        chk("degen_out", W'(out2[3]), W'(1));
        chk("degen_rise", rise2, 18'h00008);
        chk("degen_tick", W'(tick2), W'(1));

        repeat (3000) begin
            if ($urandom_range(3, 0) == 0) raw[$urandom_range(2, 0)] ^= 1'b1;
            else if ($urandom_range(19, 0) == 0) raw[$urandom_range(W - 1, 0)] ^= 1'b1;
            rst = ($urandom_range(399, 0) == 0);
            cyc();
        end
        rst = 1'b0;
        repeat (20) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
